// File: rtl/snake_pkg.sv
// Shared encodings for the snake engine: directions, game-state codes, FSM states.
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  localparam logic [1:0] GS_PLAY      = 2'b01;
  localparam logic [1:0] GS_GAME_OVER = 2'b11;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Direction that would fold the head straight back onto the neck.
  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/snake_if.sv
// Bus between game controller / pixel renderer and the snake engine.
interface snake_if #(
  parameter int BIT = 10,
  parameter int LW  = 5
);
  logic           update;
  logic           grow;
  logic [2:0]     direction;
  logic [1:0]     game_state;
  logic [BIT-1:0] x_pos;
  logic [BIT-1:0] y_pos;
  logic           snake_head_active;
  logic           snake_body_active;
  logic [LW-1:0]  length;
  logic [1:0]     collision;
  logic           collision_valid;
  logic [2:0]     rgb;

  modport master (
    output update, grow, direction, game_state, x_pos, y_pos,
    input  snake_head_active, snake_body_active, length, collision, collision_valid, rgb
  );

  modport slave (
    input  update, grow, direction, game_state, x_pos, y_pos,
    output snake_head_active, snake_body_active, length, collision, collision_valid, rgb
  );
endinterface

// File: rtl/snake_seg_hit.sv
// Combinational "pixel inside this SIZE x SIZE square" test for one segment.
module snake_seg_hit #(
  parameter int SIZE = 5,
  parameter int BIT  = 10
) (
  input  logic [BIT-1:0] x_pos,
  input  logic [BIT-1:0] y_pos,
  input  logic [BIT-1:0] seg_x,
  input  logic [BIT-1:0] seg_y,
  output logic           hit
);
  logic [BIT:0] x_end, y_end;

  // Far edges on one extra bit; a square spilling past the coordinate range is never drawn.
  assign x_end = {1'b0, seg_x} + (BIT+1)'(SIZE);
  assign y_end = {1'b0, seg_y} + (BIT+1)'(SIZE);

  assign hit = !x_end[BIT] && !y_end[BIT] &&
               (x_pos >= seg_x) && ({1'b0, x_pos} < x_end) &&
               (y_pos >= seg_y) && ({1'b0, y_pos} < y_end);
endmodule

// File: rtl/snake_engine.sv
// Snake head/body engine: move/check FSM, grow, collisions, registered pixel hit flags.
module snake_engine
  import snake_pkg::*;
#(
  parameter int SIZE     = 5,
  parameter int BIT      = 10,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int X_START  = 320,
  parameter int Y_START  = 240,
  parameter int X_MAX    = 640,
  parameter int Y_MAX    = 480
) (
  input logic   clk,
  input logic   reset,
  snake_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  typedef logic [MAX_LEN-1:0][BIT-1:0] seg_arr_t;

  function automatic seg_arr_t seg_x_init();
    seg_arr_t s;
    for (int i = 0; i < MAX_LEN; i++) s[i] = BIT'(X_START - (i + 1) * SIZE);
    return s;
  endfunction

  localparam seg_arr_t       SX0   = seg_x_init();
  localparam seg_arr_t       SY0   = {MAX_LEN{BIT'(Y_START)}};
  localparam logic [BIT-1:0] STEP  = BIT'(SIZE);
  localparam logic [BIT-1:0] X0    = BIT'(X_START);
  localparam logic [BIT-1:0] Y0    = BIT'(Y_START);
  localparam logic [BIT-1:0] X_LIM = BIT'(X_MAX - SIZE);
  localparam logic [BIT-1:0] Y_LIM = BIT'(Y_MAX - SIZE);

  state_t                 state, state_nxt;
  logic [BIT-1:0]         hx, hy, nhx, nhy;
  seg_arr_t               sx, sy;
  logic [LW-1:0]          len;
  dir_t                   cur_dir, req;
  logic                   grow_pend;
  logic [1:0]             coll;
  logic                   coll_vld, head_act, body_act;
  logic                   play, over, go, req_ok, moving;
  logic                   wall, self_hit, body_hit;
  logic [MAX_LEN:0]       hits;
  logic [MAX_LEN:0][BIT-1:0] px_all, py_all;

  assign play   = (bus.game_state == GS_PLAY);
  assign over   = (bus.game_state == GS_GAME_OVER);
  assign go     = (state == ST_WAIT) && bus.update && play && (coll == 2'b00);
  assign req    = dir_t'(bus.direction);
  assign req_ok = (bus.direction <= 3'd4) && (req != opposite(cur_dir));
  assign moving = (state == ST_MOVE) && (cur_dir != DIR_IDLE);

  // Index 0 is the head, index i+1 is body segment i.
  assign px_all = {sx, hx};
  assign py_all = {sy, hy};

  for (genvar g = 0; g <= MAX_LEN; g++) begin : g_hit
    snake_seg_hit #(.SIZE(SIZE), .BIT(BIT)) u_hit (
      .x_pos (bus.x_pos),
      .y_pos (bus.y_pos),
      .seg_x (px_all[g]),
      .seg_y (py_all[g]),
      .hit   (hits[g])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_WAIT;
    else        state <= state_nxt;
  end

  // FSM next state: WAIT -> MOVE -> CHECK -> WAIT; GAME_OVER forces WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT:  if (go) state_nxt = ST_MOVE;
      ST_MOVE:  state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_WAIT;
      default:  state_nxt = ST_WAIT;
    endcase
    if (over) state_nxt = ST_WAIT;
  end

  // Next head position one step along the current direction (wraps mod 2^BIT).
  always_comb begin
    nhx = hx;
    nhy = hy;
    case (cur_dir)
      DIR_UP:    nhy = hy - STEP;
      DIR_DOWN:  nhy = hy + STEP;
      DIR_LEFT:  nhx = hx - STEP;
      DIR_RIGHT: nhx = hx + STEP;
      default:   ;
    endcase
  end

  // Collision terms and body pixel hit, restricted to the active length.
  always_comb begin
    wall     = (hx > X_LIM) || (hy > Y_LIM);
    self_hit = 1'b0;
    body_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < len) begin
        if (sx[i] == hx && sy[i] == hy) self_hit = 1'b1;
        if (hits[i+1])                  body_hit = 1'b1;
      end
    end
  end

  // Snake state, collision flags and registered pixel flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hx        <= X0;
      hy        <= Y0;
      sx        <= SX0;
      sy        <= SY0;
      len       <= LW'(INIT_LEN);
      cur_dir   <= DIR_IDLE;
      grow_pend <= 1'b0;
      coll      <= 2'b00;
      coll_vld  <= 1'b0;
      head_act  <= 1'b0;
      body_act  <= 1'b0;
    end else begin
      head_act <= hits[0];
      body_act <= body_hit;
      if (over) begin
        hx        <= X0;
        hy        <= Y0;
        sx        <= SX0;
        sy        <= SY0;
        len       <= LW'(INIT_LEN);
        cur_dir   <= DIR_IDLE;
        grow_pend <= 1'b0;
        coll      <= 2'b00;
        coll_vld  <= 1'b0;
      end else begin
        coll_vld  <= 1'b0;
        // A grow landing on the consuming move stays pending for the next one.
        grow_pend <= (grow_pend & ~moving) | (bus.grow & play);
        if (go && req_ok) cur_dir <= req;
        if (moving) begin
          hx <= nhx;
          hy <= nhy;
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            sx[i] <= sx[i-1];
            sy[i] <= sy[i-1];
          end
          sx[0] <= hx;
          sy[0] <= hy;
          if (grow_pend && len < LW'(MAX_LEN)) len <= len + LW'(1);
        end
        if (state == ST_CHECK) begin
          coll     <= coll | {self_hit, wall};
          coll_vld <= 1'b1;
        end
      end
    end
  end

  assign bus.snake_head_active = head_act;
  assign bus.snake_body_active = body_act;
  assign bus.length            = len;
  assign bus.collision         = coll;
  assign bus.collision_valid   = coll_vld;
  assign bus.rgb               = 3'b010;

endmodule
